// File: rtl/axi_pkg.sv
// Shared AXI read-arbiter types: FSM state encodings, master tags and the latched AR request.
package axi_pkg;

  localparam int unsigned AXI_ID_BITS  = 4;
  localparam int unsigned AXI_IDS_BITS = 8;
  localparam int unsigned AXI_LEN_BITS = 4;
  localparam int unsigned TAG_W        = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic [TAG_W-1:0] TAG_M0 = 4'b0001;
  localparam logic [TAG_W-1:0] TAG_M1 = 4'b0010;

  typedef struct packed {
    logic [AXI_ID_BITS-1:0]  id;
    logic [31:0]             addr;
    logic [AXI_LEN_BITS-1:0] len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } ar_req_t;

  // Slave-side ID tag for the master index (0 = M0, 1 = M1).
  function automatic logic [TAG_W-1:0] tag_of(input logic m);
    return m ? TAG_M1 : TAG_M0;
  endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin pick: lone requester wins, a tie goes to the master not granted last.
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_c,
  output logic       any_c
);

  always_comb begin
    any_c = |req;
    gnt_c = last_grant;
    case (req)
      2'b01:   gnt_c = 1'b0;
      2'b10:   gnt_c = 1'b1;
      2'b11:   gnt_c = ~last_grant;
      default: gnt_c = last_grant;
    endcase
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Two-master AXI read-channel arbiter in front of the boot/program ROM slave.
// One burst at a time, round-robin grant, R beats routed back to the owner.
module rom_read_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned ID_W  = AXI_ID_BITS,
  parameter int unsigned IDS_W = AXI_IDS_BITS,
  parameter int unsigned LEN_W = AXI_LEN_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ID_W-1:0]  ARID_M0,
  input  logic [31:0]      ARADDR_M0,
  input  logic [LEN_W-1:0] ARLEN_M0,
  input  logic [2:0]       ARSIZE_M0,
  input  logic [1:0]       ARBURST_M0,
  input  logic             ARVALID_M0,
  output logic             ARREADY_M0,
  output logic [ID_W-1:0]  RID_M0,
  output logic [31:0]      RDATA_M0,
  output logic [1:0]       RRESP_M0,
  output logic             RLAST_M0,
  output logic             RVALID_M0,
  input  logic             RREADY_M0,
  input  logic [ID_W-1:0]  ARID_M1,
  input  logic [31:0]      ARADDR_M1,
  input  logic [LEN_W-1:0] ARLEN_M1,
  input  logic [2:0]       ARSIZE_M1,
  input  logic [1:0]       ARBURST_M1,
  input  logic             ARVALID_M1,
  output logic             ARREADY_M1,
  output logic [ID_W-1:0]  RID_M1,
  output logic [31:0]      RDATA_M1,
  output logic [1:0]       RRESP_M1,
  output logic             RLAST_M1,
  output logic             RVALID_M1,
  input  logic             RREADY_M1,
  output logic [IDS_W-1:0] ARID_S,
  output logic [31:0]      ARADDR_S,
  output logic [LEN_W-1:0] ARLEN_S,
  output logic [2:0]       ARSIZE_S,
  output logic [1:0]       ARBURST_S,
  output logic             ARVALID_S,
  input  logic             ARREADY_S,
  input  logic [IDS_W-1:0] RID_S,
  input  logic [31:0]      RDATA_S,
  input  logic [1:0]       RRESP_S,
  input  logic             RLAST_S,
  input  logic             RVALID_S,
  output logic             RREADY_S,
  output logic             proto_err
);

  logic [1:0]       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  ar_req_t          req_q, req_d;
  logic             proto_err_q, proto_err_d;

  logic    pick_c;
  logic    any_c;
  logic    rready_c;
  ar_req_t req_m0_c;
  ar_req_t req_m1_c;

  assign req_m0_c  = {ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0};
  assign req_m1_c  = {ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1};
  assign proto_err = proto_err_q;

  rr_grant2 u_rr_grant2 (
    .req        ({ARVALID_M1, ARVALID_M0}),
    .last_grant (last_grant_q),
    .gnt_c      (pick_c),
    .any_c      (any_c)
  );

  // Next-state, datapath update and (combinational) channel outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    req_d        = req_q;
    proto_err_d  = proto_err_q;
    rready_c     = 1'b0;

    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    RID_M0     = '0;
    RDATA_M0   = '0;
    RRESP_M0   = '0;
    RLAST_M0   = 1'b0;
    RVALID_M0  = 1'b0;
    RID_M1     = '0;
    RDATA_M1   = '0;
    RRESP_M1   = '0;
    RLAST_M1   = 1'b0;
    RVALID_M1  = 1'b0;
    ARID_S     = '0;
    ARADDR_S   = '0;
    ARLEN_S    = '0;
    ARSIZE_S   = '0;
    ARBURST_S  = '0;
    ARVALID_S  = 1'b0;
    RREADY_S   = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_c) begin
          grant_d = pick_c;
          req_d   = pick_c ? req_m1_c : req_m0_c;
          state_d = ADDR;
        end
      end

      ADDR: begin
        ARVALID_S = 1'b1;
        ARID_S    = {tag_of(grant_q), req_q.id};
        ARADDR_S  = req_q.addr;
        ARLEN_S   = req_q.len;
        ARSIZE_S  = req_q.size;
        ARBURST_S = req_q.burst;
        if (ARREADY_S) begin
          ARREADY_M0   = ~grant_q;
          ARREADY_M1   = grant_q;
          last_grant_d = grant_q;
          beat_cnt_d   = '0;
          state_d      = DATA;
        end
      end

      DATA: begin
        rready_c = grant_q ? RREADY_M1 : RREADY_M0;
        RREADY_S = rready_c;
        if (grant_q) begin
          RID_M1    = RID_S[ID_W-1:0];
          RDATA_M1  = RDATA_S;
          RRESP_M1  = RRESP_S;
          RLAST_M1  = RLAST_S;
          RVALID_M1 = RVALID_S;
        end else begin
          RID_M0    = RID_S[ID_W-1:0];
          RDATA_M0  = RDATA_S;
          RRESP_M0  = RRESP_S;
          RLAST_M0  = RLAST_S;
          RVALID_M0 = RVALID_S;
        end
        // Burst-length and ID-tag checks on every accepted beat.
        if (RVALID_S && rready_c) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if (RLAST_S) begin
            if (beat_cnt_q != req_q.len) proto_err_d = 1'b1;
            state_d = IDLE;
          end else if (beat_cnt_q == req_q.len) begin
            proto_err_d = 1'b1;
          end
          if (RID_S[IDS_W-1:ID_W] != tag_of(grant_q)) proto_err_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      req_q        <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      req_q        <= req_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: grant order, AR forwarding, R routing, errors, reset.
module tb_rom_read_arbiter;

  localparam int unsigned ID_W  = 4;
  localparam int unsigned IDS_W = 8;
  localparam int unsigned LEN_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic [ID_W-1:0]  ARID_M0, ARID_M1, RID_M0, RID_M1;
  logic [31:0]      ARADDR_M0, ARADDR_M1, RDATA_M0, RDATA_M1;
  logic [LEN_W-1:0] ARLEN_M0, ARLEN_M1;
  logic [2:0]       ARSIZE_M0, ARSIZE_M1;
  logic [1:0]       ARBURST_M0, ARBURST_M1, RRESP_M0, RRESP_M1;
  logic             ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
  logic             RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
  logic [IDS_W-1:0] ARID_S, RID_S;
  logic [31:0]      ARADDR_S, RDATA_S;
  logic [LEN_W-1:0] ARLEN_S;
  logic [2:0]       ARSIZE_S;
  logic [1:0]       ARBURST_S, RRESP_S;
  logic             ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S, proto_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rom_read_arbiter #(.ID_W(ID_W), .IDS_W(IDS_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
    .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .proto_err(proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic set_ar(input bit m, input logic v, input logic [3:0] id,
                        input logic [31:0] addr, input logic [3:0] len);
    if (m) begin
      ARVALID_M1 = v; ARID_M1 = id; ARADDR_M1 = addr; ARLEN_M1 = len;
      ARSIZE_M1 = 3'd2; ARBURST_M1 = 2'd1;
    end else begin
      ARVALID_M0 = v; ARID_M0 = id; ARADDR_M0 = addr; ARLEN_M0 = len;
      ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1;
    end
  endtask

  // Called one cycle after the request was presented (arbiter in ADDR).
  task automatic addr_phase(input bit m, input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input int wait_cyc, input bit drop);
    for (int i = 0; i < wait_cyc; i++) begin
      #1;
      chk("arvalid_s_hold", ARVALID_S, 1);
      tick();
    end
    #1;
    chk("arvalid_s", ARVALID_S, 1);
    chk("arid_s", ARID_S, {(m ? 4'h2 : 4'h1), id});
    chk("araddr_s", ARADDR_S, addr);
    chk("arlen_s", ARLEN_S, len);
    chk("arsize_s", ARSIZE_S, 3'd2);
    chk("arburst_s", ARBURST_S, 2'd1);
    chk("arready_before_s", m ? ARREADY_M1 : ARREADY_M0, 0);
    ARREADY_S = 1'b1;
    #1;
    chk("arready_granted", m ? ARREADY_M1 : ARREADY_M0, 1);
    chk("arready_other", m ? ARREADY_M0 : ARREADY_M1, 0);
    tick();
    ARREADY_S = 1'b0;
    if (drop) begin
      if (m) ARVALID_M1 = 1'b0;
      else ARVALID_M0 = 1'b0;
    end
  endtask

  // Drives n R beats from the slave; RLAST on beat last_idx; optional 3-cycle master stall.
  task automatic beats(input bit m, input int n, input int last_idx,
                       input logic [7:0] rid, input int stall_at);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = 32'hD000_0000 | 32'(i) | (m ? 32'h0100_0000 : 32'h0);
      RVALID_S = 1'b1; RDATA_S = d; RID_S = rid; RRESP_S = 2'b00;
      RLAST_S = (i == last_idx);
      if (i == stall_at) begin
        if (m) RREADY_M1 = 1'b0;
        else RREADY_M0 = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk("stall_rready_s", RREADY_S, 0);
          chk("stall_rvalid_own", m ? RVALID_M1 : RVALID_M0, 1);
          tick();
        end
        if (m) RREADY_M1 = 1'b1;
        else RREADY_M0 = 1'b1;
      end
      #1;
      chk("rvalid_own", m ? RVALID_M1 : RVALID_M0, 1);
      chk("rdata_own", m ? RDATA_M1 : RDATA_M0, d);
      chk("rid_own", m ? RID_M1 : RID_M0, rid[3:0]);
      chk("rlast_own", m ? RLAST_M1 : RLAST_M0, (i == last_idx) ? 1 : 0);
      chk("rvalid_other", m ? RVALID_M0 : RVALID_M1, 0);
      chk("rdata_other", m ? RDATA_M0 : RDATA_M1, 0);
      chk("rready_s", RREADY_S, 1);
      tick();
    end
    RVALID_S = 1'b0;
    RLAST_S  = 1'b0;
    RDATA_S  = '0;
    RID_S    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    set_ar(0, 1'b0, 4'h0, 32'h0, 4'h0);
    set_ar(1, 1'b0, 4'h0, 32'h0, 4'h0);
    RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
    ARREADY_S = 1'b0; RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 1'b0; RVALID_S = 1'b0;
    tick();
    tick();
    chk("rst_arvalid_s", ARVALID_S, 0);
    chk("rst_arid_s", ARID_S, 0);
    chk("rst_araddr_s", ARADDR_S, 0);
    chk("rst_rready_s", RREADY_S, 0);
    chk("rst_rvalid_m0", RVALID_M0, 0);
    chk("rst_arready_m0", ARREADY_M0, 0);
    chk("rst_proto_err", proto_err, 0);
    rst = 1'b1;
    tick();

    // M0 alone, 4-beat burst, slave accepts the address after 2 wait cycles.
    set_ar(0, 1'b1, 4'h5, 32'h0000_0010, 4'd3);
    #1;
    chk("idle_arready_m0", ARREADY_M0, 0);
    chk("idle_arvalid_s", ARVALID_S, 0);
    tick();
    addr_phase(0, 4'h5, 32'h0000_0010, 4'd3, 2, 1'b1);
    beats(0, 4, 3, 8'h15, -1);
    #1;
    chk("t1_idle_arvalid_s", ARVALID_S, 0);
    chk("t1_idle_rready_s", RREADY_S, 0);
    chk("t1_proto_err", proto_err, 0);
    tick();

    // Simultaneous requests right after reset: M0 first, then M1 after one bubble.
    do_reset();
    set_ar(0, 1'b1, 4'h3, 32'h0000_0100, 4'd1);
    set_ar(1, 1'b1, 4'h7, 32'h0000_0200, 4'd0);
    tick();
    addr_phase(0, 4'h3, 32'h0000_0100, 4'd1, 0, 1'b1);
    #1;
    chk("t2_m1_waits", ARREADY_M1, 0);
    beats(0, 2, 1, 8'h13, -1);
    #1;
    chk("t2_bubble_arvalid_s", ARVALID_S, 0);
    tick();
    addr_phase(1, 4'h7, 32'h0000_0200, 4'd0, 0, 1'b1);
    beats(1, 1, 0, 8'h27, -1);
    #1;
    chk("t2_proto_err", proto_err, 0);

    // M1 keeps requesting, M0 requests once: M1, M0, M1; M0 stalls RREADY for 3 cycles.
    set_ar(1, 1'b1, 4'h9, 32'h0000_0300, 4'd0);
    tick();
    set_ar(0, 1'b1, 4'h4, 32'h0000_0400, 4'd2);
    addr_phase(1, 4'h9, 32'h0000_0300, 4'd0, 0, 1'b0);
    beats(1, 1, 0, 8'h29, -1);
    tick();
    addr_phase(0, 4'h4, 32'h0000_0400, 4'd2, 0, 1'b1);
    beats(0, 3, 2, 8'h14, 1);
    tick();
    addr_phase(1, 4'h9, 32'h0000_0300, 4'd0, 0, 1'b1);
    beats(1, 1, 0, 8'h29, -1);
    #1;
    chk("t3_proto_err", proto_err, 0);

    // Early RLAST (beat 2 of ARLEN=3) sets a sticky error; the next burst still completes.
    set_ar(0, 1'b1, 4'h2, 32'h0000_0500, 4'd3);
    tick();
    addr_phase(0, 4'h2, 32'h0000_0500, 4'd3, 0, 1'b1);
    beats(0, 2, 1, 8'h12, -1);
    #1;
    chk("t5_early_last_err", proto_err, 1);
    set_ar(1, 1'b1, 4'h6, 32'h0000_0600, 4'd0);
    tick();
    addr_phase(1, 4'h6, 32'h0000_0600, 4'd0, 0, 1'b1);
    beats(1, 1, 0, 8'h26, -1);
    #1;
    chk("t5_err_sticky", proto_err, 1);

    // Wrong RID tag: data still routed to M0, error raised.
    do_reset();
    #1;
    chk("t5_err_cleared", proto_err, 0);
    set_ar(0, 1'b1, 4'h1, 32'h0000_0700, 4'd0);
    tick();
    addr_phase(0, 4'h1, 32'h0000_0700, 4'd0, 0, 1'b1);
    beats(0, 1, 0, 8'h21, -1);
    #1;
    chk("t5_tag_err", proto_err, 1);

    // ARLEN=0 without RLAST on the first beat: error, stays in DATA until RLAST.
    do_reset();
    set_ar(1, 1'b1, 4'h8, 32'h0000_0800, 4'd0);
    tick();
    addr_phase(1, 4'h8, 32'h0000_0800, 4'd0, 0, 1'b1);
    beats(1, 2, 1, 8'h28, -1);
    #1;
    chk("t5_missing_last_err", proto_err, 1);
    chk("t5_back_idle", ARVALID_S, 0);

    // Reset asserted while beat 2 is on the bus.
    do_reset();
    set_ar(0, 1'b1, 4'h5, 32'h0000_0900, 4'd3);
    tick();
    addr_phase(0, 4'h5, 32'h0000_0900, 4'd3, 0, 1'b1);
    beats(0, 1, 3, 8'h15, -1);
    RVALID_S = 1'b1; RDATA_S = 32'hBEEF_0001; RID_S = 8'h15; RLAST_S = 1'b0;
    #1;
    chk("t6_beat2_visible", RVALID_M0, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_rvalid_m0", RVALID_M0, 0);
    chk("t6_rst_rdata_m0", RDATA_M0, 0);
    chk("t6_rst_rready_s", RREADY_S, 0);
    chk("t6_rst_arvalid_s", ARVALID_S, 0);
    tick();
    chk("t6_rst_hold_rvalid_m0", RVALID_M0, 0);
    chk("t6_rst_proto_err", proto_err, 0);
    RVALID_S = 1'b0; RDATA_S = '0; RID_S = '0;
    rst = 1'b1;
    set_ar(1, 1'b1, 4'hA, 32'h0000_0A00, 4'd0);
    #1;
    chk("t6_idle_arvalid_s", ARVALID_S, 0);
    tick();
    addr_phase(1, 4'hA, 32'h0000_0A00, 4'd0, 0, 1'b1);
    beats(1, 1, 0, 8'h2A, -1);
    #1;
    chk("t6_proto_err", proto_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
